rtc_bcd_clock: RTL and testbench

Parametrised real-time clock that generates its own 1 s tick from clk and keeps BCD hours, minutes and seconds. Runtime-selectable 12 h or 24 h display. Loadable through a valid/ready time-set handshake with range checking. Drives the board's 7-segment time display and any logic that needs a seconds tick or a midnight event.

---
 rtl/rtc_pkg.sv | 31 +++
 rtl/bcd_mod_counter.sv | 19 +
 rtl/rtc_bcd_clock.sv | 90 +++++++++
 tb/tb_rtc_bcd_clock.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared BCD types, limits, load FSM states and hour conversion helpers
package rtc_pkg;
  typedef logic [7:0] bcd_t;
  localparam bcd_t BCD_59 = 8'h59;
  localparam bcd_t BCD_23 = 8'h23;
  localparam bcd_t BCD_12 = 8'h12;
  typedef enum logic {IDLE, LOAD} state_t;
  function automatic logic bcd_valid(bcd_t b, bcd_t max);
    return b[7:4] <= 4'd9 && b[3:0] <= 4'd9 && b <= max;
  endfunction
  function automatic logic [4:0] bcd_to_bin(bcd_t b);
    return 5'(b[7:4]) * 5'd10 + 5'(b[3:0]);
  endfunction
  function automatic bcd_t bin_to_bcd(logic [4:0] v);
    return {4'(v / 5'd10), 4'(v % 5'd10)};
  endfunction
  function automatic bcd_t bcd_inc(bcd_t b, bcd_t max);
    return b == max ? 8'h00 : b[3:0] == 4'd9 ? {b[7:4] + 4'd1, 4'h0} : b + 8'd1;
  endfunction
  function automatic bcd_t to_h24(bcd_t h12, logic is_pm);
    logic [4:0] b;
    b = bcd_to_bin(h12);
    return bin_to_bcd(h12 == BCD_12 ? (is_pm ? 5'd12 : 5'd0) : is_pm ? b + 5'd12 : b);
  endfunction
  function automatic logic [8:0] to_h12(bcd_t h24);
    logic [4:0] b;
    b = bcd_to_bin(h24);
    return b == 5'd0 ? {1'b0, BCD_12} : b < 5'd12 ? {1'b0, h24} :
           b == 5'd12 ? {1'b1, BCD_12} : {1'b1, bin_to_bcd(b - 5'd12)};
  endfunction
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: loadable BCD counter wrapping MAX_BCD -> 00 with carry out
module bcd_mod_counter import rtc_pkg::*; #(
  parameter bcd_t MAX_BCD = BCD_59
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic load,
  input  bcd_t load_val,
  output bcd_t q,
  output logic carry
);
  assign carry = inc && q == MAX_BCD;
  // load has priority over increment
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= 8'h00;
    else if (load) q <= load_val;
    else if (inc) q <= bcd_inc(q, MAX_BCD);
endmodule

// File: rtl/rtc_bcd_clock.sv
// rtc_bcd_clock: BCD real-time clock, 12/24 h display, checked time load; RTC_ALARM_EN adds an alarm
module rtc_bcd_clock import rtc_pkg::*; #(
  parameter int CLK_DIV = 100_000_000,
  parameter int DIV_W = $clog2(CLK_DIV)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ena,
  input  logic mode_24h,
  input  logic set_valid,
  output logic set_ready,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic set_pm,
  output logic set_err,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic pm,
  output logic tick,
`ifdef RTC_ALARM_EN
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic alarm_arm,
  input  logic alarm_ack,
  output logic alarm,
`endif
  output logic day_wrap
);
  logic [DIV_W-1:0] div_q;
  state_t state;
  bcd_t ss_q, mm_q, h24_q, load_h24;
  logic ss_c, mm_c, h_c, sec_tick, accept, ok, load, tick_en;
  logic [8:0] h12;
  assign sec_tick = ena && div_q == DIV_W'(CLK_DIV - 1);
  assign accept = set_valid && set_ready && state == IDLE;
  assign ok = bcd_valid(set_mm, BCD_59) && bcd_valid(set_ss, BCD_59) &&
              (mode_24h ? bcd_valid(set_hh, BCD_23) : bcd_valid(set_hh, BCD_12) && set_hh != 8'h00);
  assign load = accept && ok;
  assign tick_en = sec_tick && !load;
  assign load_h24 = mode_24h ? set_hh : to_h24(set_hh, set_pm);
  assign h12 = to_h12(h24_q);
  // prescaler: restarts on load, frozen while ena is low
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) div_q <= '0;
    else if (load) div_q <= '0;
    else if (ena) div_q <= sec_tick ? '0 : div_q + DIV_W'(1);
  // load handshake: one LOAD cycle after each accepted load, error pulse on rejection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      set_ready <= 1'b0;
      set_err <= 1'b0;
    end else begin
      state <= load ? LOAD : IDLE;
      set_ready <= !load;
      set_err <= accept && !ok;
    end
  bcd_mod_counter #(.MAX_BCD(BCD_59)) u_ss (.clk, .reset_n, .inc(tick_en), .load, .load_val(set_ss), .q(ss_q), .carry(ss_c));
  bcd_mod_counter #(.MAX_BCD(BCD_59)) u_mm (.clk, .reset_n, .inc(ss_c), .load, .load_val(set_mm), .q(mm_q), .carry(mm_c));
  bcd_mod_counter #(.MAX_BCD(BCD_23)) u_hh (.clk, .reset_n, .inc(mm_c), .load, .load_val(load_h24), .q(h24_q), .carry(h_c));
  // registered display and event pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hh <= 8'h00;
      mm <= 8'h00;
      ss <= 8'h00;
      pm <= 1'b0;
      tick <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      hh <= mode_24h ? h24_q : h12[7:0];
      mm <= mm_q;
      ss <= ss_q;
      pm <= !mode_24h && h12[8];
      tick <= tick_en;
      day_wrap <= h_c;
    end
`ifdef RTC_ALARM_EN
  bcd_t mm_next, h_next;
  assign mm_next = bcd_inc(mm_q, BCD_59);
  assign h_next = mm_c ? bcd_inc(h24_q, BCD_23) : h24_q;
  // alarm fires on the tick that rolls into alarm_hh:alarm_mm:00; setting beats ack
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) alarm <= 1'b0;
    else if (alarm_arm && ss_c && mm_next == alarm_mm && h_next == alarm_hh) alarm <= 1'b1;
    else if (alarm_ack || !alarm_arm) alarm <= 1'b0;
`endif
endmodule

// File: tb/tb_rtc_bcd_clock.sv
// tb_rtc_bcd_clock: vector table, hand sequences and random run against a seconds-of-day model
module tb_rtc_bcd_clock;
  localparam int DIV = 4;
  logic clk = 0, reset_n = 1, ena = 0, mode_24h = 0, set_valid = 0, set_pm = 0;
  logic [7:0] set_hh = 0, set_mm = 0, set_ss = 0;
  logic set_ready, set_err, pm, tick, day_wrap;
  logic [7:0] hh, mm, ss;
`ifdef RTC_ALARM_EN
  logic [7:0] alarm_hh = 8'h10, alarm_mm = 8'h31;
  logic alarm_arm = 0, alarm_ack = 0, alarm;
`endif
  int checks = 0, errors = 0;
  int m_secs, m_pc, m_dsecs;
  bit m_rdy, m_dmode, m_dv, m_tick, m_dw, m_err;
  typedef struct {
    logic [7:0] hh, mm, ss;
    logic pm, mode, err;
    logic [7:0] ehh;
    logic epm;
  } vec_t;
  vec_t tbl[12];

  rtc_bcd_clock #(.CLK_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .mode_24h(mode_24h),
    .set_valid(set_valid), .set_ready(set_ready), .set_hh(set_hh), .set_mm(set_mm),
    .set_ss(set_ss), .set_pm(set_pm), .set_err(set_err), .hh(hh), .mm(mm), .ss(ss),
    .pm(pm), .tick(tick),
`ifdef RTC_ALARM_EN
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm),
    .alarm_ack(alarm_ack), .alarm(alarm),
`endif
    .day_wrap(day_wrap));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dig(logic [7:0] b);
    return (b[7:4] > 9 || b[3:0] > 9) ? 99 : b[7:4] * 10 + b[3:0];
  endfunction

  function automatic logic [7:0] tobcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  task automatic mreset;
    m_secs = 0; m_pc = 0; m_dsecs = 0;
    m_rdy = 0; m_dmode = 0; m_dv = 0; m_tick = 0; m_dw = 0; m_err = 0;
  endtask

  task automatic mstep;
    int h, m, s;
    bit acc, ok, ld, sec;
    h = dig(set_hh); m = dig(set_mm); s = dig(set_ss);
    acc = set_valid && m_rdy;
    ok = m <= 59 && s <= 59 && (mode_24h ? h <= 23 : (h >= 1 && h <= 12));
    ld = acc && ok;
    sec = ena && m_pc == DIV - 1;
    m_dsecs = m_secs; m_dmode = mode_24h; m_dv = 1;
    m_tick = 0; m_dw = 0; m_err = acc && !ok; m_rdy = !ld;
    if (ld) begin
      m_secs = (mode_24h ? h : h % 12 + (set_pm ? 12 : 0)) * 3600 + m * 60 + s;
      m_pc = 0;
    end else begin
      if (ena) m_pc = (m_pc + 1) % DIV;
      if (sec) begin
        m_tick = 1;
        m_dw = m_secs == 86399;
        m_secs = (m_secs + 1) % 86400;
      end
    end
  endtask

  task automatic compare;
    int h;
    h = m_dsecs / 3600;
    chk("hh", hh, !m_dv ? 8'h00 : m_dmode ? tobcd(h) : tobcd(h % 12 == 0 ? 12 : h % 12));
    chk("mm", mm, tobcd(m_dsecs / 60 % 60));
    chk("ss", ss, tobcd(m_dsecs % 60));
    chk("pm", pm, m_dv && !m_dmode && h >= 12);
    chk("tick", tick, m_tick);
    chk("day_wrap", day_wrap, m_dw);
    chk("set_err", set_err, m_err);
    chk("set_ready", set_ready, m_rdy);
  endtask

  task automatic cycle;
    mstep;
    @(posedge clk);
    #1;
    compare;
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
    set_hh = h; set_mm = m; set_ss = s; set_pm = p; set_valid = 1;
    cycle;
    set_valid = 0;
  endtask

  initial begin
    int nt, nw;
    logic [7:0] ss_hold;
    tbl = '{
      '{8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0},
      '{8'h12, 8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1},
      '{8'h08, 8'h15, 8'h00, 1'b1, 1'b0, 1'b0, 8'h08, 1'b1},
      '{8'h23, 8'h59, 8'h59, 1'b0, 1'b1, 1'b0, 8'h23, 1'b0},
      '{8'h09, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h09, 1'b0},
      '{8'h13, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h09, 1'b0},
      '{8'h24, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h09, 1'b0},
      '{8'h00, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 8'h09, 1'b0},
      '{8'h10, 8'h60, 8'h00, 1'b0, 1'b1, 1'b1, 8'h09, 1'b0},
      '{8'h10, 8'h10, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h09, 1'b0},
      '{8'h1A, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 8'h09, 1'b0},
      '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0}};
    #1 reset_n = 0;
    mreset;
    repeat (2) @(posedge clk);
    #1;
    compare;
    reset_n = 1;
    cycle;
    chk("rst_hh12", hh, 8'h12);
    chk("rst_ready", set_ready, 1);
    foreach (tbl[i]) begin
      mode_24h = tbl[i].mode;
      load(tbl[i].hh, tbl[i].mm, tbl[i].ss, tbl[i].pm);
      chk("tbl_err", set_err, tbl[i].err);
      cycle;
      chk("tbl_hh", hh, tbl[i].ehh);
      chk("tbl_pm", pm, tbl[i].epm);
      chk("tbl_ready", set_ready, 1);
    end
    mode_24h = 0; ena = 1;
    load(8'h11, 8'h59, 8'h58, 1'b1);
    nt = 0; nw = 0;
    for (int i = 0; i < 9; i++) begin
      cycle;
      nt += tick; nw += day_wrap;
      if (day_wrap) chk("dw_with_tick", tick, 1);
    end
    chk("mid_ticks", nt, 2);
    chk("mid_wraps", nw, 1);
    chk("mid_hh", hh, 8'h12);
    chk("mid_mm", mm, 8'h00);
    chk("mid_ss", ss, 8'h00);
    chk("mid_pm", pm, 0);
    ena = 0; mode_24h = 1;
    load(8'h13, 8'h05, 8'h00, 1'b0);
    cycle;
    chk("m24_hh", hh, 8'h13);
    chk("m24_pm", pm, 0);
    mode_24h = 0;
    cycle;
    chk("m12_hh", hh, 8'h01);
    chk("m12_pm", pm, 1);
    chk("m12_mm", mm, 8'h05);
    ena = 1; mode_24h = 1;
    for (int i = 0; i < DIV && m_pc != DIV - 1; i++) cycle;
    chk("col_at_top", m_pc, DIV - 1);
    load(8'h07, 8'h07, 8'h07, 1'b0);
    chk("col_no_tick", tick, 0);
    ena = 0;
    cycle;
    chk("col_ss", ss, 8'h07);
    ss_hold = ss; nt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle;
      nt += tick;
    end
    chk("frz_ticks", nt, 0);
    chk("frz_ss", ss, ss_hold);
    for (int i = 0; i < 600; i++) begin
      ena = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 15) == 0) mode_24h = ~mode_24h;
      set_valid = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 1) == 1) begin
        set_hh = mode_24h ? 8'h23 : 8'h11;
        set_mm = 8'h59;
        set_ss = tobcd($urandom_range(54, 59));
        set_pm = 1;
      end else begin
        set_hh = 8'($urandom_range(0, 8'h25));
        set_mm = 8'($urandom_range(0, 8'h62));
        set_ss = 8'($urandom_range(0, 8'h62));
        set_pm = 1'($urandom_range(0, 1));
      end
      cycle;
    end
    set_valid = 0; ena = 0; mode_24h = 1;
    load(8'h10, 8'h30, 8'h45, 1'b0);
    cycle;
    chk("pre_rst_hh", hh, 8'h10);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("arst_hh", hh, 0);
    chk("arst_mm", mm, 0);
    chk("arst_ss", ss, 0);
    chk("arst_ready", set_ready, 0);
    chk("arst_pulses", {tick, day_wrap, set_err, pm}, 0);
    mreset;
    @(posedge clk);
    #1;
    compare;
    reset_n = 1;
    cycle;
`ifdef RTC_ALARM_EN
    alarm_arm = 1;
    load(8'h10, 8'h30, 8'h59, 1'b0);
    chk("alm_load", alarm, 0);
    ena = 1;
    for (int i = 0; i < 2 * DIV && !tick; i++) cycle;
    chk("alm_tick_seen", tick, 1);
    chk("alm_set", alarm, 1);
    ena = 0; alarm_ack = 1;
    cycle;
    chk("alm_ack", alarm, 0);
    alarm_ack = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
